// File: rtl/video_timing_gen.sv
// Parametrised raster timing generator and pixel gate for the HDMI/DVI TX path.
// Optional colour-bar fill on FIFO underflow: define VIDEO_TIMING_TEST_PATTERN_EN.
module video_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 12,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 31,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int REQ_LEAD = 1,
  parameter int CW       = 11,
  parameter int PW       = 24
) (
  input  logic          clk,
  input  logic          rstin,
  input  logic          enable,
  input  logic          pix_valid,
  input  logic [PW-1:0] pix_data,
  input  logic          clr_underflow,
  output logic          pix_req,
  output logic [CW-1:0] hcount,
  output logic [CW-1:0] vcount,
  output logic          hsync,
  output logic          vsync,
  output logic          de,
  output logic          frame_start,
  output logic [PW-1:0] pix_out,
  output logic          underflow
);

  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HS_START = H_ACTIVE + H_FP;
  localparam int HS_END   = HS_START + H_SYNC;
  localparam int VS_START = V_ACTIVE + V_FP;
  localparam int VS_END   = VS_START + V_SYNC;
  localparam int H_LAST_I = H_TOTAL - 1;
  localparam int V_LAST_I = V_TOTAL - 1;

  localparam logic [CW-1:0] H_LAST     = H_LAST_I[CW-1:0];
  localparam logic [CW-1:0] V_LAST     = V_LAST_I[CW-1:0];
  localparam logic [CW-1:0] CNT_ONE    = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW:0]   EXT_ONE    = {{CW{1'b0}}, 1'b1};
  localparam logic [CW:0]   H_TOT_W    = H_TOTAL[CW:0];
  localparam logic [CW:0]   H_ACT_W    = H_ACTIVE[CW:0];
  localparam logic [CW:0]   V_ACT_W    = V_ACTIVE[CW:0];
  localparam logic [CW:0]   HS_START_W = HS_START[CW:0];
  localparam logic [CW:0]   HS_END_W   = HS_END[CW:0];
  localparam logic [CW:0]   VS_START_W = VS_START[CW:0];
  localparam logic [CW:0]   VS_END_W   = VS_END[CW:0];
  localparam logic [CW:0]   LEAD_W     = REQ_LEAD[CW:0];

  logic [CW-1:0] h_r, v_r;
  logic [CW-1:0] h_nxt_s, v_nxt_s;
  logic [CW:0]   h_ext_s, v_ext_s;
  logic [CW:0]   h_lead_sum_s, h_lead_s, v_lead_s;
  logic          de_s, req_s, hs_act_s, vs_act_s, first_s, miss_s;
  logic [PW-1:0] fill_s;

`ifdef VIDEO_TIMING_TEST_PATTERN_EN
  // Bar index is the count of bar edges k*H_ACTIVE/8 the column has passed.
  function automatic logic [PW-1:0] bar_colour(input logic [CW-1:0] col);
    logic [CW+2:0] col8;
    logic [2:0]    idx;
    col8 = {col, 3'b000};
    idx  = 3'd0;
    for (int k = 1; k < 8; k++) begin
      if (int'(col8) >= k * H_ACTIVE) idx = 3'(k);
    end
    case (idx)
      3'd0:    bar_colour = PW'(24'hFFFFFF);
      3'd1:    bar_colour = PW'(24'h00FFFF);
      3'd2:    bar_colour = PW'(24'hFFFF00);
      3'd3:    bar_colour = PW'(24'h00FF00);
      3'd4:    bar_colour = PW'(24'hFF00FF);
      3'd5:    bar_colour = PW'(24'h0000FF);
      3'd6:    bar_colour = PW'(24'hFF0000);
      default: bar_colour = PW'(24'h000000);
    endcase
  endfunction
`endif

  // Next raster position and the position REQ_LEAD cycles ahead (at most one line wrap).
  always_comb begin
    h_ext_s = {1'b0, h_r};
    v_ext_s = {1'b0, v_r};
    if (h_r == H_LAST) begin
      h_nxt_s = '0;
      v_nxt_s = (v_r == V_LAST) ? '0 : v_r + CNT_ONE;
    end else begin
      h_nxt_s = h_r + CNT_ONE;
      v_nxt_s = v_r;
    end
    h_lead_sum_s = h_ext_s + LEAD_W;
    if (h_lead_sum_s >= H_TOT_W) begin
      h_lead_s = h_lead_sum_s - H_TOT_W;
      v_lead_s = (v_r == V_LAST) ? '0 : v_ext_s + EXT_ONE;
    end else begin
      h_lead_s = h_lead_sum_s;
      v_lead_s = v_ext_s;
    end
    de_s     = (h_ext_s < H_ACT_W) && (v_ext_s < V_ACT_W);
    req_s    = (h_lead_s < H_ACT_W) && (v_lead_s < V_ACT_W);
    hs_act_s = (h_ext_s >= HS_START_W) && (h_ext_s < HS_END_W);
    vs_act_s = (v_ext_s >= VS_START_W) && (v_ext_s < VS_END_W);
    first_s  = (h_r == '0) && (v_r == '0);
  end

  // Raster counters and registered timing outputs; counters idle on the last
  // blank line so the first enabled line gives pix_req room to lead.
  always_ff @(posedge clk or posedge rstin) begin
    if (rstin) begin
      h_r         <= '0;
      v_r         <= V_LAST;
      hcount      <= '0;
      vcount      <= '0;
      de          <= 1'b0;
      pix_req     <= 1'b0;
      frame_start <= 1'b0;
      hsync       <= ~HS_POL;
      vsync       <= ~VS_POL;
    end else if (!enable) begin
      h_r         <= '0;
      v_r         <= V_LAST;
      hcount      <= '0;
      vcount      <= '0;
      de          <= 1'b0;
      pix_req     <= 1'b0;
      frame_start <= 1'b0;
      hsync       <= ~HS_POL;
      vsync       <= ~VS_POL;
    end else begin
      h_r         <= h_nxt_s;
      v_r         <= v_nxt_s;
      hcount      <= h_r;
      vcount      <= v_r;
      de          <= de_s;
      pix_req     <= req_s;
      frame_start <= first_s;
      hsync       <= hs_act_s ? HS_POL : ~HS_POL;
      vsync       <= vs_act_s ? VS_POL : ~VS_POL;
    end
  end

  // Sticky underflow: a miss in the same cycle as a clear keeps the flag set.
  always_ff @(posedge clk or posedge rstin) begin
    if (rstin) begin
      underflow <= 1'b0;
    end else begin
      underflow <= miss_s | (underflow & ~clr_underflow);
    end
  end

  // Pixel gate onto the active region.
  always_comb begin
    miss_s = de & ~pix_valid;
`ifdef VIDEO_TIMING_TEST_PATTERN_EN
    fill_s = bar_colour(hcount);
`else
    fill_s = '0;
`endif
    if (de && pix_valid) begin
      pix_out = pix_data;
    end else if (de) begin
      pix_out = fill_s;
    end else begin
      pix_out = '0;
    end
  end

endmodule

// File: tb/tb_video_timing_gen.sv
// Directed bench for video_timing_gen: 640x480 (REQ_LEAD=2), 720p (REQ_LEAD=0)
// and a tiny 15x8 raster (REQ_LEAD=6, maximum lead) sharing clock and controls.
module tb_video_timing_gen;

  logic        clk = 1'b0;
  logic        rstin;
  logic        enable;
  logic        pix_valid;
  logic [23:0] pix_data;
  logic        clr_underflow;

  logic        d_pix_req, d_hsync, d_vsync, d_de, d_fs, d_uf;
  logic [10:0] d_hcount, d_vcount;
  logic [23:0] d_pix_out;
  logic        hd_pix_req, hd_hsync, hd_vsync, hd_de, hd_fs, hd_uf;
  logic [11:0] hd_hcount, hd_vcount;
  logic [23:0] hd_pix_out;
  logic        sm_pix_req, sm_hsync, sm_vsync, sm_de, sm_fs, sm_uf;
  logic [3:0]  sm_hcount, sm_vcount;
  logic [23:0] sm_pix_out;

  int k = 0;
  int n_pass = 0;
  int n_fail = 0;
  int n_total = 0;

`ifdef VIDEO_TIMING_TEST_PATTERN_EN
  localparam logic [23:0] MISS_PIX = 24'hFFFFFF;
`else
  localparam logic [23:0] MISS_PIX = 24'h000000;
`endif
  localparam logic [23:0] PIX_A = 24'hA5C33C;

  always #5 clk = ~clk;

  video_timing_gen #(.REQ_LEAD(2)) u_dut (
    .clk(clk), .rstin(rstin), .enable(enable), .pix_valid(pix_valid),
    .pix_data(pix_data), .clr_underflow(clr_underflow), .pix_req(d_pix_req),
    .hcount(d_hcount), .vcount(d_vcount), .hsync(d_hsync), .vsync(d_vsync),
    .de(d_de), .frame_start(d_fs), .pix_out(d_pix_out), .underflow(d_uf)
  );

  video_timing_gen #(
    .H_ACTIVE(1280), .H_FP(110), .H_SYNC(40), .H_BP(220),
    .V_ACTIVE(720), .V_FP(5), .V_SYNC(5), .V_BP(20),
    .HS_POL(1'b1), .VS_POL(1'b1), .REQ_LEAD(0), .CW(12)
  ) u_hd (
    .clk(clk), .rstin(rstin), .enable(enable), .pix_valid(pix_valid),
    .pix_data(pix_data), .clr_underflow(clr_underflow), .pix_req(hd_pix_req),
    .hcount(hd_hcount), .vcount(hd_vcount), .hsync(hd_hsync), .vsync(hd_vsync),
    .de(hd_de), .frame_start(hd_fs), .pix_out(hd_pix_out), .underflow(hd_uf)
  );

  video_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .HS_POL(1'b1), .VS_POL(1'b0), .REQ_LEAD(6), .CW(4)
  ) u_sm (
    .clk(clk), .rstin(rstin), .enable(enable), .pix_valid(pix_valid),
    .pix_data(pix_data), .clr_underflow(clr_underflow), .pix_req(sm_pix_req),
    .hcount(sm_hcount), .vcount(sm_vcount), .hsync(sm_hsync), .vsync(sm_vsync),
    .de(sm_de), .frame_start(sm_fs), .pix_out(sm_pix_out), .underflow(sm_uf)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to 1 time unit after the target-th rising edge since reset release.
  task automatic goto(input int target);
    while (k < target) begin
      @(posedge clk);
      #1;
      k++;
    end
  endtask

  initial begin
    rstin = 1'b1; enable = 1'b1; pix_valid = 1'b1; pix_data = PIX_A; clr_underflow = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_hcount", d_hcount, 32'd0);
    chk("rst_vcount", d_vcount, 32'd0);
    chk("rst_de", d_de, 32'd0);
    chk("rst_req", d_pix_req, 32'd0);
    chk("rst_hsync", d_hsync, 32'd1);
    chk("rst_vsync", d_vsync, 32'd1);
    chk("rst_uf", d_uf, 32'd0);
    chk("rst_pix", d_pix_out, 32'd0);
    chk("rst_hd_hsync", hd_hsync, 32'd0);
    chk("rst_sm_hsync", sm_hsync, 32'd0);
    rstin = 1'b0;

    // First line after reset is the last blank line.
    goto(1);
    chk("k1_hcount", d_hcount, 32'd0);
    chk("k1_vcount", d_vcount, 32'd524);
    chk("k1_de", d_de, 32'd0);
    chk("k1_hsync", d_hsync, 32'd1);
    chk("k1_vsync", d_vsync, 32'd1);
    chk("k1_hd_vsync", hd_vsync, 32'd0);
    chk("k1_hd_vcount", hd_vcount, 32'd749);
    chk("k1_sm_vcount", sm_vcount, 32'd7);

    // Tiny raster: 15 cycles/line, 8 lines, lead 6.
    goto(9);   chk("sm_req_pre", sm_pix_req, 32'd0);
    goto(10);  chk("sm_req_rise", sm_pix_req, 32'd1);
    goto(15);  chk("sm_de_pre", sm_de, 32'd0);
    goto(16);
    chk("sm_de_rise", sm_de, 32'd1);
    chk("sm_fs", sm_fs, 32'd1);
    chk("sm_fs_h", sm_hcount, 32'd0);
    chk("sm_fs_v", sm_vcount, 32'd0);
    goto(17);
    chk("sm_fs_once", sm_fs, 32'd0);
    chk("sm_req_hi", sm_pix_req, 32'd1);
    goto(18);  chk("sm_req_fall", sm_pix_req, 32'd0);
    goto(23);  chk("sm_de_last", sm_de, 32'd1);
    goto(24);
    chk("sm_de_fall", sm_de, 32'd0);
    chk("sm_req_gap", sm_pix_req, 32'd0);
    goto(25);
    chk("sm_req_line1", sm_pix_req, 32'd1);
    chk("sm_hs_pre", sm_hsync, 32'd0);
    goto(26);  chk("sm_hs_on", sm_hsync, 32'd1);
    goto(28);  chk("sm_hs_last", sm_hsync, 32'd1);
    goto(29);  chk("sm_hs_off", sm_hsync, 32'd0);
    goto(30);
    chk("sm_hwrap_h", sm_hcount, 32'd14);
    chk("sm_hwrap_v", sm_vcount, 32'd0);
    goto(31);
    chk("sm_line1_h", sm_hcount, 32'd0);
    chk("sm_line1_v", sm_vcount, 32'd1);
    goto(90);  chk("sm_vs_pre", sm_vsync, 32'd1);
    goto(91);  chk("sm_vs_on", sm_vsync, 32'd0);
    goto(120); chk("sm_vs_last", sm_vsync, 32'd0);
    goto(121); chk("sm_vs_off", sm_vsync, 32'd1);
    goto(129); chk("sm_req_fw_pre", sm_pix_req, 32'd0);
    goto(130); chk("sm_req_fw", sm_pix_req, 32'd1);
    goto(136); chk("sm_fs_frame2", sm_fs, 32'd1);

    // 640x480 horizontal sync in the blank line.
    goto(656); chk("hs_pre", d_hsync, 32'd1);
    goto(657); chk("hs_on", d_hsync, 32'd0);
    goto(752); chk("hs_last", d_hsync, 32'd0);
    goto(753); chk("hs_off", d_hsync, 32'd1);
    goto(798); chk("req_pre", d_pix_req, 32'd0);
    goto(799); chk("req_rise", d_pix_req, 32'd1);
    goto(800);
    chk("de_pre", d_de, 32'd0);
    chk("h_last", d_hcount, 32'd799);
    goto(801);
    chk("de_rise", d_de, 32'd1);
    chk("fs", d_fs, 32'd1);
    chk("fs_h", d_hcount, 32'd0);
    chk("fs_v", d_vcount, 32'd0);
    goto(802); chk("fs_once", d_fs, 32'd0);

    goto(1390); chk("hd_hs_pre", hd_hsync, 32'd0);
    goto(1391); chk("hd_hs_on", hd_hsync, 32'd1);
    goto(1430); chk("hd_hs_last", hd_hsync, 32'd1);
    goto(1431); chk("hd_hs_off", hd_hsync, 32'd0);

    goto(1438); chk("req_last", d_pix_req, 32'd1);
    goto(1439); chk("req_fall", d_pix_req, 32'd0);
    goto(1440); chk("de_last", d_de, 32'd1);
    goto(1441);
    chk("de_fall", d_de, 32'd0);
    chk("de_fall_h", d_hcount, 32'd640);
    chk("blank_pix", d_pix_out, 32'd0);
    goto(1598); chk("req_l1_pre", d_pix_req, 32'd0);
    goto(1599); chk("req_l1", d_pix_req, 32'd1);
    goto(1601);
    chk("de_l1", d_de, 32'd1);
    chk("de_l1_h", d_hcount, 32'd0);
    chk("de_l1_v", d_vcount, 32'd1);

    goto(1650);
    chk("hd_hlast", hd_hcount, 32'd1649);
    chk("hd_req_pre", hd_pix_req, 32'd0);
    goto(1651);
    chk("hd_h0", hd_hcount, 32'd0);
    chk("hd_v0", hd_vcount, 32'd0);
    chk("hd_de", hd_de, 32'd1);
    chk("hd_req_eq_de", hd_pix_req, 32'd1);
    chk("hd_fs", hd_fs, 32'd1);

    // pix_valid low outside de is ignored.
    goto(4800);
    pix_valid = 1'b0;
    #1;
    chk("blank_miss_pix", d_pix_out, 32'd0);
    goto(4801);
    pix_valid = 1'b1;
    chk("blank_miss_uf", d_uf, 32'd0);

    // Single miss at pixel (10,5).
    goto(4811);
    pix_valid = 1'b0;
    #1;
    chk("miss_de", d_de, 32'd1);
    chk("miss_h", d_hcount, 32'd10);
    chk("miss_v", d_vcount, 32'd5);
    chk("miss_pix", d_pix_out, MISS_PIX);
    chk("miss_uf_pre", d_uf, 32'd0);
    goto(4812);
    pix_valid = 1'b1;
    #1;
    chk("miss_uf_set", d_uf, 32'd1);
    chk("pass_pix", d_pix_out, PIX_A);

    // Clear together with a new miss: set wins.
    goto(4820);
    pix_valid = 1'b0; clr_underflow = 1'b1;
    goto(4821);
    pix_valid = 1'b1; clr_underflow = 1'b0;
    chk("set_wins", d_uf, 32'd1);
    clr_underflow = 1'b1;
    goto(4822);
    clr_underflow = 1'b0;
    chk("uf_clear", d_uf, 32'd0);

    // Enable dropped mid-line with underflow pending.
    goto(5890);
    pix_valid = 1'b0;
    goto(5891);
    pix_valid = 1'b1;
    chk("uf_set2", d_uf, 32'd1);
    goto(5901);
    chk("drop_h", d_hcount, 32'd300);
    chk("drop_v", d_vcount, 32'd6);
    chk("drop_de_pre", d_de, 32'd1);
    enable = 1'b0;
    goto(5902);
    chk("off_de", d_de, 32'd0);
    chk("off_req", d_pix_req, 32'd0);
    chk("off_h", d_hcount, 32'd0);
    chk("off_v", d_vcount, 32'd0);
    chk("off_hsync", d_hsync, 32'd1);
    chk("off_sm_hsync", sm_hsync, 32'd0);
    goto(5905);
    chk("off_uf_kept", d_uf, 32'd1);
    goto(5906);
    enable = 1'b1;
    goto(5907);
    chk("re_h", d_hcount, 32'd0);
    chk("re_v", d_vcount, 32'd524);
    chk("re_de", d_de, 32'd0);
    goto(6704); chk("re_req_pre", d_pix_req, 32'd0);
    goto(6705); chk("re_req", d_pix_req, 32'd1);
    goto(6706); chk("re_de_pre", d_de, 32'd0);
    goto(6707);
    chk("re_de_rise", d_de, 32'd1);
    chk("re_fs", d_fs, 32'd1);
    chk("re_fs_h", d_hcount, 32'd0);
    chk("re_fs_v", d_vcount, 32'd0);
    goto(6708);
    chk("re_fs_once", d_fs, 32'd0);
    clr_underflow = 1'b1;
    goto(6709);
    clr_underflow = 1'b0;
    chk("uf_clear2", d_uf, 32'd0);

    // Asynchronous reset mid-line, between clock edges.
    goto(6711);
    pix_valid = 1'b0;
    goto(6712);
    pix_valid = 1'b1;
    chk("pre_arst_uf", d_uf, 32'd1);
    chk("pre_arst_de", d_de, 32'd1);
    rstin = 1'b1;
    #2;
    chk("arst_h", d_hcount, 32'd0);
    chk("arst_v", d_vcount, 32'd0);
    chk("arst_de", d_de, 32'd0);
    chk("arst_uf", d_uf, 32'd0);
    chk("arst_hsync", d_hsync, 32'd1);
    chk("arst_pix", d_pix_out, 32'd0);
    chk("arst_sm_hsync", sm_hsync, 32'd0);
    chk("arst_hd_vsync", hd_vsync, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
